msm_operand_loader: RTL and testbench

MSM_OPERAND_LOADER -- requirements
Module: msm_operand_loader

---
 rtl/msm_operand_loader_pkg.sv | 20 ++
 rtl/msm_operand_loader_if.sv | 26 ++
 rtl/msm_operand_loader.sv | 114 +++++++++++
 tb/tb_msm_operand_loader.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/msm_operand_loader_pkg.sv
// Shared curve types and loader state encoding for the MSM operand loader.
// Points are projective (x, y, z); the point at infinity is (0, 1, 0).
package elliptic_curve_structs;

    typedef struct packed {
        logic [255:0] x;
        logic [255:0] y;
        logic [255:0] z;
    } curve_point_t;

    localparam curve_point_t inf_point = '{x: 256'd0, y: 256'd1, z: 256'd0};

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        KICK = 2'd1,
        RUN  = 2'd2,
        HOLD = 2'd3
    } loader_state_t;

endpackage

// File: rtl/msm_operand_loader_if.sv
// Operand-in and result-out handshake bundle for the MSM operand loader.
// Both channels use valid/ready: a beat moves on a rising clk edge where valid and ready are both 1;
// the source holds its payload stable while valid is high and ready is low, and never retracts valid.
interface msm_operand_loader_if;
    import elliptic_curve_structs::*;

    logic         in_valid;
    logic         in_ready;
    curve_point_t in_point;
    logic [255:0] in_scalar;
    logic         in_last;
    logic         res_valid;
    logic         res_ready;
    curve_point_t res_point;

    modport master (
        output in_valid, in_point, in_scalar, in_last, res_ready,
        input  in_ready, res_valid, res_point
    );

    modport slave (
        input  in_valid, in_point, in_scalar, in_last, res_ready,
        output in_ready, res_valid, res_point
    );

endinterface

// File: rtl/msm_operand_loader.sv
// Buffers LENGTH (point, scalar) beats, kicks the external MSM, and hands back its result.
// Optional short-job padding via in_last is enabled by defining MSM_LOADER_PAD_EN.
module msm_operand_loader
    import elliptic_curve_structs::*;
#(
    parameter int LENGTH = 256
) (
    input  logic                       clk,
    input  logic                       Reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  curve_point_t               in_point,
    input  logic [255:0]               in_scalar,
`ifdef MSM_LOADER_PAD_EN
    input  logic                       in_last,
`endif
    output curve_point_t [LENGTH-1:0]  G,
    output logic [LENGTH-1:0][255:0]   x,
    output logic                       msm_reset,
    input  logic                       msm_done,
    input  curve_point_t               msm_R,
    output logic                       res_valid,
    input  logic                       res_ready,
    output curve_point_t               res_point,
    output loader_state_t              state
);

    localparam int CW = (LENGTH > 1) ? $clog2(LENGTH) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(LENGTH - 1);

    loader_state_t state_q, state_d;
    logic [CW-1:0] cnt;
    logic          accept;
    logic          final_beat;

    assign accept = in_valid && in_ready;

`ifdef MSM_LOADER_PAD_EN
    assign final_beat = accept && ((cnt == LAST_IDX) || in_last);
`else
    assign final_beat = accept && (cnt == LAST_IDX);
`endif

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) state_q <= LOAD;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        msm_reset = 1'b1;
        case (state_q)
            LOAD: begin
                in_ready = !Reset;
                if (final_beat) state_d = KICK;
            end
            KICK: state_d = RUN;
            RUN: begin
                msm_reset = 1'b0;
                if (msm_done) state_d = HOLD;
            end
            HOLD: if (res_ready) state_d = LOAD;
            default: state_d = LOAD;
        endcase
    end

    assign state = state_q;

    // cnt parks on the final beat's index until the job drains, so it never wraps mid-job.
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            cnt <= '0;
        end else if (accept && !final_beat) begin
            cnt <= cnt + 1'b1;
        end else if (state_q == HOLD && res_ready) begin
            cnt <= '0;
        end
    end

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < LENGTH; i++) begin
                G[i] <= inf_point;
                x[i] <= '0;
            end
        end else if (accept) begin
            G[cnt] <= in_point;
            x[cnt] <= in_scalar;
`ifdef MSM_LOADER_PAD_EN
            // Unfilled tail of a short job becomes identity terms so the MSM sum is unaffected.
            for (int i = 0; i < LENGTH; i++) begin
                if (in_last && (i > int'(cnt))) begin
                    G[i] <= inf_point;
                    x[i] <= '0;
                end
            end
`endif
        end
    end

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            res_valid <= 1'b0;
            res_point <= inf_point;
        end else if (state_q == RUN && msm_done) begin
            res_valid <= 1'b1;
            res_point <= msm_R;
        end else if (state_q == HOLD && res_ready) begin
            res_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_msm_operand_loader.sv
// Directed bench for msm_operand_loader with LENGTH=4 and a small stand-in MSM
// whose result is the coordinate-wise sum of scalar*point (z forced to 1).
module tb_msm_operand_loader;
    import elliptic_curve_structs::*;

    localparam int L = 4;

    logic clk;
    logic Reset;
    logic msm_reset;
    logic msm_done;
    logic force_done;
    curve_point_t msm_R;
    curve_point_t [L-1:0] G;
    logic [L-1:0][255:0] x;
    loader_state_t state;

    int errors;
    int checks;

    msm_operand_loader_if bus();

    msm_operand_loader #(.LENGTH(L)) dut (
        .clk       (clk),
        .Reset     (Reset),
        .in_valid  (bus.in_valid),
        .in_ready  (bus.in_ready),
        .in_point  (bus.in_point),
        .in_scalar (bus.in_scalar),
`ifdef MSM_LOADER_PAD_EN
        .in_last   (bus.in_last),
`endif
        .G         (G),
        .x         (x),
        .msm_reset (msm_reset),
        .msm_done  (msm_done),
        .msm_R     (msm_R),
        .res_valid (bus.res_valid),
        .res_ready (bus.res_ready),
        .res_point (bus.res_point),
        .state     (state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // stand-in MSM: Done rises 5 cycles after its Reset drops and holds until reset again
    int msm_cyc;
    always @(posedge clk) begin
        if (msm_reset) msm_cyc <= 0;
        else if (msm_cyc < 6) msm_cyc <= msm_cyc + 1;
    end
    assign msm_done = (!msm_reset && msm_cyc >= 5) || force_done;

    always_comb begin
        msm_R = '{x: 256'd0, y: 256'd0, z: 256'd1};
        for (int i = 0; i < L; i++) begin
            msm_R.x = msm_R.x + G[i].x * x[i];
            msm_R.y = msm_R.y + G[i].y * x[i];
        end
    end

    function automatic curve_point_t mkpt(input int i);
        mkpt = '{x: 256'(i + 1), y: 256'(10 * (i + 1)), z: 256'd1};
    endfunction

    // scoreboard
    task automatic chk(input string tag, input logic [767:0] obs, input logic [767:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_result(input string tag);
        int n;
        n = 0;
        while (!bus.res_valid && n < 50) begin
            chk({tag, "_run_msm_reset"}, msm_reset, 1'b0);
            step();
            n++;
        end
        chk({tag, "_result_timeout"}, bus.res_valid, 1'b1);
    endtask

    initial begin
        errors = 0;
        checks = 0;
        force_done = 1'b0;
        Reset = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_point = inf_point;
        bus.in_scalar = '0;
        bus.in_last = 1'b0;
        bus.res_ready = 1'b0;

        // reset values
        #2;
        chk("rst_in_ready", bus.in_ready, 1'b0);
        chk("rst_msm_reset", msm_reset, 1'b1);
        chk("rst_res_valid", bus.res_valid, 1'b0);
        chk("rst_res_point", bus.res_point, inf_point);
        chk("rst_g0", G[0], inf_point);
        chk("rst_g3", G[3], inf_point);
        chk("rst_x3", x[3], 256'd0);
        @(posedge clk);
        #1;
        Reset = 1'b0;
        #1;
        chk("post_rst_in_ready", bus.in_ready, 1'b1);
        chk("post_rst_state", state, LOAD);
        step();

        // job 1: beats offered every other cycle
        for (int i = 0; i < L; i++) begin
            bus.in_valid = 1'b1;
            bus.in_point = mkpt(i);
            bus.in_scalar = 256'(i + 1);
            chk("load_in_ready", bus.in_ready, 1'b1);
            step();
            bus.in_valid = 1'b0;
            if (i < L - 1) begin
                chk("load_idle_state", state, LOAD);
                step();
            end
        end
        chk("kick_state", state, KICK);
        chk("kick_msm_reset", msm_reset, 1'b1);
        chk("kick_in_ready", bus.in_ready, 1'b0);
        for (int i = 0; i < L; i++) begin
            chk("job1_g", G[i], mkpt(i));
            chk("job1_x", x[i], 256'(i + 1));
        end
        // fifth beat must wait
        bus.in_valid = 1'b1;
        bus.in_point = mkpt(9);
        bus.in_scalar = 256'd99;
        step();
        chk("run_state", state, RUN);
        chk("run_in_ready", bus.in_ready, 1'b0);
        wait_result("job1");
        chk("job1_res_point", bus.res_point, {256'd30, 256'd300, 256'd1});
        chk("job1_hold_state", state, HOLD);

        // result held while res_ready low
        for (int k = 0; k < 10; k++) begin
            step();
            chk("hold_res_valid", bus.res_valid, 1'b1);
            chk("hold_res_point", bus.res_point, {256'd30, 256'd300, 256'd1});
            chk("hold_msm_reset", msm_reset, 1'b1);
            chk("hold_in_ready", bus.in_ready, 1'b0);
            chk("hold_g0", G[0], mkpt(0));
        end
        bus.res_ready = 1'b1;
        step();
        bus.res_ready = 1'b0;
        bus.in_valid = 1'b0;
        chk("drain_res_valid", bus.res_valid, 1'b0);
        chk("drain_state", state, LOAD);
        chk("drain_g0_unchanged", G[0], mkpt(0));
        chk("drain_x0_unchanged", x[0], 256'd1);

        // msm_done outside RUN is ignored
        force_done = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("early_done_res_valid", bus.res_valid, 1'b0);
            chk("early_done_state", state, LOAD);
        end
        force_done = 1'b0;

        // job 2: two beats then asynchronous reset
        bus.in_valid = 1'b1;
        bus.in_point = mkpt(4);
        bus.in_scalar = 256'd5;
        step();
        bus.in_point = mkpt(5);
        bus.in_scalar = 256'd6;
        step();
        bus.in_valid = 1'b0;
        chk("job2_g1", G[1], mkpt(5));
        chk("job2_x0", x[0], 256'd5);
        #1;
        Reset = 1'b1;
        #1;
        chk("abort_state", state, LOAD);
        chk("abort_g0", G[0], inf_point);
        chk("abort_g1", G[1], inf_point);
        chk("abort_x1", x[1], 256'd0);
        chk("abort_in_ready", bus.in_ready, 1'b0);
        chk("abort_res_point", bus.res_point, inf_point);
        #1;
        Reset = 1'b0;
        step();

        // job 3: first beat lands in entry 0, then reset during RUN
        for (int i = 0; i < L; i++) begin
            bus.in_valid = 1'b1;
            bus.in_point = mkpt(6 + i);
            bus.in_scalar = 256'(11 + i);
            step();
            if (i == 0) begin
                chk("job3_g0", G[0], mkpt(6));
                chk("job3_x0", x[0], 256'd11);
            end
        end
        bus.in_valid = 1'b0;
        chk("job3_kick", state, KICK);
        step();
        step();
        step();
        chk("job3_run", state, RUN);
        #1;
        Reset = 1'b1;
        #1;
        chk("run_abort_state", state, LOAD);
        chk("run_abort_res_valid", bus.res_valid, 1'b0);
        chk("run_abort_g3", G[3], inf_point);
        chk("run_abort_x2", x[2], 256'd0);
        #1;
        Reset = 1'b0;
        for (int k = 0; k < 10; k++) step();
        chk("run_abort_no_result", bus.res_valid, 1'b0);
        chk("run_abort_idle", state, LOAD);

`ifdef MSM_LOADER_PAD_EN
        // short job: in_last on the second beat pads entries 2..3
        bus.in_valid = 1'b1;
        bus.in_point = mkpt(0);
        bus.in_scalar = 256'd1;
        bus.in_last = 1'b0;
        step();
        bus.in_point = mkpt(1);
        bus.in_scalar = 256'd2;
        bus.in_last = 1'b1;
        step();
        bus.in_valid = 1'b0;
        bus.in_last = 1'b0;
        chk("pad_kick", state, KICK);
        chk("pad_g1", G[1], mkpt(1));
        chk("pad_g2", G[2], inf_point);
        chk("pad_g3", G[3], inf_point);
        chk("pad_x2", x[2], 256'd0);
        chk("pad_x3", x[3], 256'd0);
        step();
        wait_result("pad");
        chk("pad_res_point", bus.res_point, {256'd5, 256'd50, 256'd1});
        bus.res_ready = 1'b1;
        step();
        bus.res_ready = 1'b0;
        chk("pad_drain", state, LOAD);
`endif

        // final report
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
